// File: rtl/mdl_xxx_bram_load_mc_if.sv
// mdl_xxx_bram_load_mc_if
//   AXI-Stream receive channel feeding the coefficient loader.
//   iRs_Tvalid / iRs_Tdata / iRs_Tlast : source -> loader
//   oRs_Tready                         : loader -> source
//   master modport = stream source (DMA), slave modport = loader.
interface mdl_xxx_bram_load_mc_if #(
   parameter int PRM_DAXI = 64
);
   logic                iRs_Tvalid;
   logic [PRM_DAXI-1:0] iRs_Tdata;
   logic                iRs_Tlast;
   logic                oRs_Tready;

   modport master (output iRs_Tvalid, iRs_Tdata, iRs_Tlast, input oRs_Tready);
   modport slave  (input iRs_Tvalid, iRs_Tdata, iRs_Tlast, output oRs_Tready);
endinterface

// File: rtl/mdl_xxx_bram_load_mc.sv
// mdl_xxx_bram_load_mc
//   AXI-Stream to BRAM coefficient loader. Each accepted beat is split into
//   PRM_LANES coefficients, optionally normalised into [0,Q) (NTT mode) and
//   written to one of PRM_BANKS BRAMs at BASE + beat*LANES + lane (wrapping).
//   Fixed latency: accept at cycle t -> write strobes at t+2; done at t+3
//   after the final accepted beat.
// Ports:
//   iSYS_CLK, iSYS_RST (sync, active high)
//   iFSM_START / oFSM_DONE / oFSM_BUSY / oERR : control and status
//   rs   : stream slave (mdl_xxx_bram_load_mc_if)
//   iCTL_BUT, iCTL_Q, iCTL_BANK, iCTL_BASE, iCTL_LEN : per-load config
//   oBK_en, oBK_we, oBK_addr, oBK_din : bank write ports
// Build option:
//   FULL_REDUCE_EN : NTT mode also subtracts Q from non-negative lanes >= Q.

// Per-lane normalise + stage-1 register.
module mdl_xxx_bram_load_mc_lane #(
   parameter int PRM_DRAM = 32
) (
   input  logic                iSYS_CLK,
   input  logic                iSYS_RST,
   input  logic                ntt,
   input  logic [PRM_DRAM-1:0] q,
   input  logic [PRM_DRAM-1:0] lane,
   output logic [PRM_DRAM-1:0] lane_q
);
   logic [PRM_DRAM-1:0] norm;

   always_comb begin
      norm = lane;
      if (ntt) begin
         // negative two's-complement lane: add Q, carry out discarded
         if (lane[PRM_DRAM-1])
            norm = lane + q;
`ifdef FULL_REDUCE_EN
         else if (lane >= q)
            norm = lane - q;
`endif
      end
   end

   always_ff @(posedge iSYS_CLK) begin
      if (iSYS_RST) lane_q <= '0;
      else          lane_q <= norm;
   end
endmodule

module mdl_xxx_bram_load_mc #(
   parameter int PRM_DAXI   = 64,
   parameter int PRM_DRAM   = 32,
   parameter int PRM_LANES  = 2,
   parameter int PRM_BANKS  = 4,
   parameter int PRM_ADDR   = 12,
   parameter int PRM_COEFFS = 4096,
   parameter int PRM_Q0     = 134250497,
   parameter int PRM_Q1     = 536903681
) (
   input  logic                          iSYS_CLK,
   input  logic                          iSYS_RST,
   input  logic                          iFSM_START,
   output logic                          oFSM_DONE,
   output logic                          oFSM_BUSY,
   output logic                          oERR,
   mdl_xxx_bram_load_mc_if.slave         rs,
   input  logic [1:0]                    iCTL_BUT,
   input  logic                          iCTL_Q,
   input  logic [$clog2(PRM_BANKS)-1:0]  iCTL_BANK,
   input  logic [PRM_ADDR-1:0]           iCTL_BASE,
   input  logic [PRM_ADDR:0]             iCTL_LEN,
   output logic [PRM_BANKS-1:0]          oBK_en,
   output logic [PRM_BANKS-1:0]          oBK_we,
   output logic [PRM_LANES*PRM_ADDR-1:0] oBK_addr,
   output logic [PRM_LANES*PRM_DRAM-1:0] oBK_din
);
   localparam int BK_W    = $clog2(PRM_BANKS);
   localparam int LANE_LG = $clog2(PRM_LANES);
   localparam logic [PRM_ADDR:0]   LEN_DEF = (PRM_ADDR+1)'(PRM_COEFFS);
   localparam logic [PRM_ADDR:0]   CNT_ONE = (PRM_ADDR+1)'(1);
   localparam logic [PRM_ADDR-1:0] ADR_INC = PRM_ADDR'(PRM_LANES);

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN0, S_DRAIN1, S_DONE} state_t;

   state_t                 state;
   logic                   cfg_ntt, cfg_q;
   logic [BK_W-1:0]        cfg_bank;
   logic [PRM_ADDR-1:0]    waddr;
   logic [PRM_ADDR:0]      beat_cnt, beats_m1, len_in;
   logic                   acc;

   logic                                 s1_vld;
   logic [BK_W-1:0]                      s1_bank;
   logic [PRM_LANES-1:0][PRM_ADDR-1:0]   s1_addr;
   logic [PRM_LANES-1:0][PRM_DRAM-1:0]   s1_data;
   logic [PRM_BANKS-1:0]                 bank_oh;
   logic [PRM_DRAM-1:0]                  q_sel;

   assign rs.oRs_Tready = (state == S_LOAD);
   assign acc           = rs.iRs_Tvalid && (state == S_LOAD);
   assign len_in        = (iCTL_LEN == '0) ? LEN_DEF : iCTL_LEN;
   assign q_sel         = cfg_q ? PRM_DRAM'(PRM_Q1) : PRM_DRAM'(PRM_Q0);
   assign bank_oh       = PRM_BANKS'(1) << s1_bank;

   // control FSM
   always_ff @(posedge iSYS_CLK) begin
      if (iSYS_RST) begin
         state     <= S_IDLE;
         oFSM_DONE <= 1'b0;
         oFSM_BUSY <= 1'b0;
         oERR      <= 1'b0;
         cfg_ntt   <= 1'b0;
         cfg_q     <= 1'b0;
         cfg_bank  <= '0;
         waddr     <= '0;
         beat_cnt  <= '0;
         beats_m1  <= '0;
      end else begin
         oFSM_DONE <= 1'b0;
         case (state)
            S_IDLE: if (iFSM_START) begin
               cfg_ntt   <= |iCTL_BUT;
               cfg_q     <= iCTL_Q;
               cfg_bank  <= iCTL_BANK;
               waddr     <= iCTL_BASE;
               beat_cnt  <= '0;
               beats_m1  <= (len_in >> LANE_LG) - CNT_ONE;
               oERR      <= 1'b0;
               oFSM_BUSY <= 1'b1;
               state     <= S_LOAD;
            end
            S_LOAD: if (acc) begin
               beat_cnt <= beat_cnt + CNT_ONE;
               waddr    <= waddr + ADR_INC;
               if (beat_cnt == beats_m1) begin
                  state <= S_DRAIN0;
                  if (!rs.iRs_Tlast) oERR <= 1'b1;
               end else if (rs.iRs_Tlast) begin
                  // early TLAST: this beat is written, the rest are dropped
                  state <= S_DRAIN0;
                  oERR  <= 1'b1;
               end
            end
            S_DRAIN0: state <= S_DRAIN1;
            S_DRAIN1: begin
               state     <= S_DONE;
               oFSM_DONE <= 1'b1;
            end
            default: begin
               state     <= S_IDLE;
               oFSM_BUSY <= 1'b0;
            end
         endcase
      end
   end

   // stage 1: lane data (in lane instances) plus address/bank
   genvar k;
   generate
      for (k = 0; k < PRM_LANES; k++) begin : g_lane
         mdl_xxx_bram_load_mc_lane #(.PRM_DRAM(PRM_DRAM)) u_lane (
            .iSYS_CLK (iSYS_CLK),
            .iSYS_RST (iSYS_RST),
            .ntt      (cfg_ntt),
            .q        (q_sel),
            .lane     (rs.iRs_Tdata[k*PRM_DRAM +: PRM_DRAM]),
            .lane_q   (s1_data[k])
         );
      end
   endgenerate

   always_ff @(posedge iSYS_CLK) begin
      if (iSYS_RST) begin
         s1_vld   <= 1'b0;
         s1_bank  <= '0;
         s1_addr  <= '0;
         oBK_en   <= '0;
         oBK_we   <= '0;
         oBK_addr <= '0;
         oBK_din  <= '0;
      end else begin
         s1_vld  <= acc;
         s1_bank <= cfg_bank;
         for (int i = 0; i < PRM_LANES; i++)
            s1_addr[i] <= waddr + PRM_ADDR'(i);
         // stage 2: registered bank ports
         oBK_en   <= s1_vld ? bank_oh : '0;
         oBK_we   <= s1_vld ? bank_oh : '0;
         oBK_addr <= s1_addr;
         oBK_din  <= s1_data;
      end
   end
endmodule

// File: doc/mdl_xxx_bram_load_mc.md
Name: mdl_xxx_bram_load_mc

Overview:
- Next-generation AXI-Stream to BRAM coefficient loader.
- Unpacks PRM_LANES coefficients per stream beat and optionally normalises signed NTT-domain values into [0,Q).
- Writes into one of PRM_BANKS coefficient BRAMs, with runtime length and base address.
- Sits between the DMA receive stream and the NTT/PWM coefficient memories.
- Adds over the previous loader: uniform pipeline latency in both modes, TLAST checking with an error flag, and a single-cycle done pulse.

Parameters:
- PRM_DAXI, 64, stream data width; must equal PRM_LANES*PRM_DRAM.
- PRM_DRAM, 32, coefficient/BRAM word width.
- PRM_LANES, 2, coefficients per beat; one BRAM write port per lane (2 or 4).
- PRM_BANKS, 4, number of target banks.
- PRM_ADDR, 12, BRAM address width.
- PRM_COEFFS, 4096, length used when iCTL_LEN==0.
- PRM_Q0, 134250497, modulus selected by iCTL_Q==0.
- PRM_Q1, 536903681, modulus selected by iCTL_Q==1.

Ports:
- iSYS_CLK  in  1  clock.
- iSYS_RST  in  1  synchronous, active-high reset.
- iFSM_START  in  1  start pulse; sampled only in IDLE.
- oFSM_DONE  out  1  one-cycle completion pulse.
- oFSM_BUSY  out  1  high outside IDLE.
- oERR  out  1  sticky TLAST mismatch flag; cleared by the next accepted start.
- iRs_Tvalid  in  1  stream valid.
- iRs_Tdata  in  PRM_DAXI  lane k = bits [k*PRM_DRAM +: PRM_DRAM].
- iRs_Tlast  in  1  stream last.
- oRs_Tready  out  1  stream ready.
- iCTL_BUT  in  2  00 = PWM raw pass-through; otherwise NTT normalise.
- iCTL_Q  in  1  modulus select.
- iCTL_BANK  in  clog2(PRM_BANKS)  target bank.
- iCTL_BASE  in  PRM_ADDR  start address; LANES-aligned.
- iCTL_LEN  in  PRM_ADDR+1  coefficient count; multiple of PRM_LANES; 0 means PRM_COEFFS.
- oBK_en  out  PRM_BANKS  one-hot bank enable.
- oBK_we  out  PRM_BANKS  one-hot bank write enable (equals oBK_en).
- oBK_addr  out  PRM_LANES*PRM_ADDR  per-lane write address.
- oBK_din  out  PRM_LANES*PRM_DRAM  per-lane write data.

Behaviour:
- Reset: every output 0; FSM returns to IDLE; counters 0. Reset mid-load abandons the transfer immediately with no further writes and no done pulse.
- Config capture: iCTL_BUT, iCTL_Q, iCTL_BANK, iCTL_BASE and iCTL_LEN are latched on the start cycle in IDLE. Changes during the load are ignored.
- FSM states:
  - IDLE: on iFSM_START, latch config, clear oERR, beat_cnt=0, go to LOAD.
  - LOAD: oRs_Tready=1 combinationally whenever in LOAD (independent of Tvalid). A beat is accepted on Tvalid&&Tready; each accept increments beat_cnt.
    - Final beat (beat_cnt==LEN/LANES-1) accepted: go to DRAIN. If Tlast==0 on that beat, set oERR.
    - Tlast==1 on an earlier beat: write that beat, set oERR, go to DRAIN; remaining words are not written.
  - DRAIN: 2 cycles, Tready=0; flushes the pipeline, then go to DONE.
  - DONE: oFSM_DONE=1 for one cycle, then go to IDLE.
- Start handling: iFSM_START is ignored outside IDLE. A start arriving in the DONE cycle is ignored.
- Pipeline: a beat accepted at cycle t produces its write strobes at t+2 in both modes. Stage 1 registers the reduced/raw lanes plus address; stage 2 registers the outputs. Done pulses at t+3 after the last accepted beat.
- Addressing: lane k of beat b is written to (BASE + b*PRM_LANES + k) mod 2^PRM_ADDR, so the address wraps silently.
- NTT normalise: if lane bit [PRM_DRAM-1] is set, out = lane + Q, computed in PRM_DRAM+1 bits and truncated to PRM_DRAM; otherwise out = lane.
- PWM mode: out = lane, unmodified.
- Stream stalls: Tvalid low produces no write strobes and holds all counters.

Optional Feature:
- Macro: FULL_REDUCE_EN.
- When defined: NTT mode additionally subtracts Q when a non-negative lane is >= Q. The result is canonical in [0,Q) for any input in (-Q, 2Q). The extra compare is absorbed into stage 1, so latency stays 2.
- When undefined: only negative lanes are corrected; non-negative lanes pass unmodified.

Test Plan:
- NTT load, PRM_COEFFS 4096, LEN=0, Q0, bank 2, base 0, beat0 lanes {-1, 5}: bank-2 addr0 = 134250496, addr1 = 5. Exactly 2048 write cycles, Tlast on beat 2047, one done pulse 3 cycles after the last accept, oERR=0.
- PWM mode, lane value 0xFFFFFFFF: written unchanged; latency 2 cycles from accept.
- Tlast on beat 9 with LEN=64: 10 beats written, oERR=1, done pulses, nothing at addresses >= 20. Next start clears oERR.
- Tvalid toggled randomly at 50%, BASE=4094, LEN=8: addresses 4094, 4095, 0, …, 5; no gaps or duplicate writes.
- Reset asserted mid-LOAD at beat 100: next cycle all outputs 0, no done pulse. A fresh start completes normally.
- FULL_REDUCE_EN defined, Q1, lane 536903690: written value 9. With the macro undefined, written value 536903690.
